// File: rtl/fast_ctrl_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fast_ctrl_pkg
// Shared types and constants for the fast-control sequencer.
//   seq_state_e : sequencer FSM states
//   MODE_*      : run-mode encodings (3 is reserved and behaves as MODE_INT)
//   DEF_PERIOD  : frame length used when a period of 0 is programmed
// -----------------------------------------------------------------------------
package fast_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      WAIT_AUX = 2'd2,
      DRAIN    = 2'd3
   } seq_state_e;

   localparam logic [1:0] MODE_INT    = 2'd0;
   localparam logic [1:0] MODE_EXT    = 2'd1;
   localparam logic [1:0] MODE_SINGLE = 2'd2;

   // Bunch crossings per orbit.
   localparam int DEF_PERIOD = 3564;

endpackage

// File: rtl/fast_ctrl_sequencer_aux_sync_edge.sv
// -----------------------------------------------------------------------------
// aux_sync_edge
// Brings the asynchronous aux trigger into the clk domain through a 2-FF
// synchronizer and emits a registered one-cycle pulse on each rising edge.
// The pulse is visible 3 clk edges after aux is first sampled high.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears all stages
//   aux   : asynchronous input
//   rise  : one-cycle pulse per rising edge of aux
// -----------------------------------------------------------------------------
module aux_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic aux,
   output logic rise
);

   logic sync1, sync2, sync2_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         sync2_d <= 1'b0;
         rise    <= 1'b0;
      end else begin
         sync1   <= aux;
         sync2   <= sync1;
         sync2_d <= sync2;
         rise    <= sync2 & ~sync2_d;
      end
   end

endmodule

// File: rtl/fast_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// fast_ctrl_sequencer
// Start/stop sequencer for the front-end fast-control strobes. Each frame
// starts with qie_reset_out high for QRST_WIDTH cycles (clamped to period-1)
// and fires wte_out for one cycle at the programmed offset.
// Modes: internal periodic, externally triggered (aux_in), single-shot.
//   clk, reset_in    : clock, asynchronous active-low reset
//   enable           : run while high; a fall finishes the current frame
//   mode             : 0 periodic, 1 external aux, 2 single-shot, 3 as 0
//   cfg_period       : frame length (0 -> DEF_PERIOD, 1 -> 2)
//   cfg_wte_offset   : phase at which wte_out fires
//   aux_in           : asynchronous external frame trigger
//   qie_reset_out    : QIE reset strobe
//   wte_out          : write-enable strobe
//   busy             : high whenever the sequencer is not idle
//   cfg_err          : offset >= period at start; WTE suppressed for that run
//   orbit_count      : frames started since the last start from idle
// -----------------------------------------------------------------------------
module fast_ctrl_sequencer #(
   parameter int PERIOD_W   = 16,
   parameter int DEF_PERIOD = fast_ctrl_pkg::DEF_PERIOD,
   parameter int QRST_WIDTH = 4,
   parameter int CNT_W      = 32
) (
   input  logic                clk,
   input  logic                reset_in,
   input  logic                enable,
   input  logic [1:0]          mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [PERIOD_W-1:0] cfg_wte_offset,
   input  logic                aux_in,
   output logic                qie_reset_out,
   output logic                wte_out,
   output logic                busy,
   output logic                cfg_err,
   output logic [CNT_W-1:0]    orbit_count
);

   import fast_ctrl_pkg::*;

   localparam logic [PERIOD_W-1:0] P_DEF  = PERIOD_W'(DEF_PERIOD);
   localparam logic [PERIOD_W-1:0] P_MIN  = PERIOD_W'(2);
   localparam logic [PERIOD_W-1:0] P_ONE  = PERIOD_W'(1);
   localparam logic [PERIOD_W-1:0] QRST_W = PERIOD_W'(QRST_WIDTH);

   seq_state_e          state_q, state_d;
   logic [PERIOD_W-1:0] phase_q, phase_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] offset_q, offset_d;
   logic [PERIOD_W-1:0] qrst_q, qrst_d;
   logic [1:0]          mode_q, mode_d;
   logic                qie_q, qie_d;
   logic                wte_q, wte_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    orbit_q, orbit_d;

   logic                aux_rise;
   logic [PERIOD_W-1:0] period_in, qrst_in;
   logic [1:0]          mode_in;
   logic                last;
   logic [PERIOD_W-1:0] np, tgt;
   logic                adv, wrap;

   aux_sync_edge u_aux (
      .clk   (clk),
      .rst_n (reset_in),
      .aux   (aux_in),
      .rise  (aux_rise)
   );

   // Configuration as it would be latched if a run started this cycle.
   always_comb begin
      if (cfg_period == '0)
         period_in = P_DEF;
      else if (cfg_period == P_ONE)
         period_in = P_MIN;
      else
         period_in = cfg_period;
      // Keep at least one reset-low cycle per frame.
      qrst_in = (QRST_W > period_in - P_ONE) ? period_in - P_ONE : QRST_W;
      mode_in = (mode == MODE_EXT || mode == MODE_SINGLE) ? mode : MODE_INT;
   end

   assign last = (phase_q == period_q - P_ONE);
   assign np   = last ? '0 : phase_q + P_ONE;

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      period_d = period_q;
      offset_d = offset_q;
      qrst_d   = qrst_q;
      mode_d   = mode_q;
      qie_d    = 1'b0;
      wte_d    = 1'b0;
      err_d    = err_q;
      orbit_d  = orbit_q;
      adv      = 1'b0;   // step to the next phase inside the frame
      wrap     = 1'b0;   // start a new frame from phase 0

      case (state_q)
         IDLE: begin
            if (enable && (mode_in != MODE_EXT || aux_rise)) begin
               state_d  = RUN;
               phase_d  = '0;
               period_d = period_in;
               offset_d = cfg_wte_offset;
               qrst_d   = qrst_in;
               mode_d   = mode_in;
               err_d    = (cfg_wte_offset >= period_in);
               qie_d    = 1'b1;
               // A bad offset is always >= 2, so offset 0 is never in error.
               wte_d    = (cfg_wte_offset == '0);
               orbit_d  = CNT_W'(1);
            end
         end
         RUN: begin
            // Stop takes priority over a coincident aux edge.
            if (!enable) begin
               if (last) state_d = IDLE;
               else begin
                  state_d = DRAIN;
                  adv     = 1'b1;
               end
            end else if (mode_q == MODE_EXT && aux_rise)
               wrap = 1'b1;
            else if (!last)
               adv = 1'b1;
            else if (mode_q == MODE_SINGLE)
               state_d = IDLE;
            else if (mode_q == MODE_EXT)
               state_d = WAIT_AUX;   // hold phase, strobes stay low
            else
               wrap = 1'b1;
         end
         WAIT_AUX: begin
            if (!enable)
               state_d = IDLE;
            else if (aux_rise) begin
               state_d = RUN;
               wrap    = 1'b1;
            end
         end
         DRAIN: begin
            // Finish the current frame only; never begin another.
            if (last) state_d = IDLE;
            else      adv     = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      tgt = wrap ? '0 : np;
      if (adv || wrap) begin
         phase_d = tgt;
         qie_d   = (tgt < qrst_q);
         wte_d   = (tgt == offset_q) && !err_q;
         if (wrap) orbit_d = orbit_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         period_q <= P_MIN;
         offset_q <= '0;
         qrst_q   <= '0;
         mode_q   <= MODE_INT;
         qie_q    <= 1'b0;
         wte_q    <= 1'b0;
         err_q    <= 1'b0;
         orbit_q  <= '0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         period_q <= period_d;
         offset_q <= offset_d;
         qrst_q   <= qrst_d;
         mode_q   <= mode_d;
         qie_q    <= qie_d;
         wte_q    <= wte_d;
         err_q    <= err_d;
         orbit_q  <= orbit_d;
      end
   end

   assign qie_reset_out = qie_q;
   assign wte_out       = wte_q;
   assign busy          = (state_q != IDLE);
   assign cfg_err       = err_q;
   assign orbit_count   = orbit_q;

endmodule

// File: tb/tb_fast_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fast_ctrl_sequencer
// Directed scenarios plus a randomized phase, all checked cycle by cycle
// against a frame-position model of the sequencer kept in this bench.
// -----------------------------------------------------------------------------
module tb_fast_ctrl_sequencer;

   localparam int PW   = 16;
   localparam int CW   = 32;
   localparam int QW   = 4;
   localparam int DEFP = 3564;

   logic          clk = 1'b0;
   logic          reset_in = 1'b0;
   logic          enable = 1'b0;
   logic          aux_in = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic [PW-1:0] cfg_period = '0;
   logic [PW-1:0] cfg_wte_offset = '0;
   logic          qie_reset_out, wte_out, busy, cfg_err;
   logic [CW-1:0] orbit_count;

   int n_cmp = 0;
   int n_bad = 0;

   fast_ctrl_sequencer #(
      .PERIOD_W   (PW),
      .DEF_PERIOD (DEFP),
      .QRST_WIDTH (QW),
      .CNT_W      (CW)
   ) dut (
      .clk            (clk),
      .reset_in       (reset_in),
      .enable         (enable),
      .mode           (mode),
      .cfg_period     (cfg_period),
      .cfg_wte_offset (cfg_wte_offset),
      .aux_in         (aux_in),
      .qie_reset_out  (qie_reset_out),
      .wte_out        (wte_out),
      .busy           (busy),
      .cfg_err        (cfg_err),
      .orbit_count    (orbit_count)
   );

   always #5 clk = ~clk;

   // Model: a frame is a position counter 0..len-1; strobes derive from it.
   bit          m_on, m_drain, m_hold, m_err;
   int          m_pos, m_len, m_off, m_mode;
   int unsigned m_cnt;
   bit          ah[5];   // aux samples at the last five edges, [0] newest

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_on = 0; m_drain = 0; m_hold = 0; m_err = 0;
      m_pos = 0; m_len = 0; m_off = 0; m_mode = 0; m_cnt = 0;
      for (int i = 0; i < 5; i++) ah[i] = 0;
   endtask

   task automatic model_step();
      bit ae, fin, stop;
      int md;
      for (int i = 4; i > 0; i--) ah[i] = ah[i-1];
      ah[0] = aux_in;
      // Synchronizer plus edge register: seen 3 edges after first sampled high.
      ae = ah[3] && !ah[4];
      md = (mode == 2'd3) ? 0 : int'(mode);
      if (!m_on) begin
         if (enable && (md != 1 || ae)) begin
            m_on = 1; m_drain = 0; m_hold = 0; m_pos = 0; m_mode = md;
            m_len = (cfg_period == 0) ? DEFP : (cfg_period == 1) ? 2 : int'(cfg_period);
            m_off = int'(cfg_wte_offset);
            m_err = (m_off >= m_len);
            m_cnt = 1;
         end
      end else if (m_hold) begin
         if (!enable) m_on = 0;
         else if (ae) begin m_hold = 0; m_pos = 0; m_cnt++; end
      end else begin
         fin  = (m_pos == m_len - 1);
         stop = m_drain || !enable;
         if (stop) begin
            if (fin) m_on = 0;
            else begin m_pos++; m_drain = 1; end
         end else if (m_mode == 1 && ae) begin
            m_pos = 0; m_cnt++;
         end else if (!fin) m_pos++;
         else if (m_mode == 2) m_on = 0;
         else if (m_mode == 1) m_hold = 1;
         else begin m_pos = 0; m_cnt++; end
      end
   endtask

   task automatic check_all(input string ctx);
      int  qw;
      bit  live;
      live = m_on && !m_hold;
      qw   = (QW < m_len - 1) ? QW : m_len - 1;
      chk({ctx, ".busy"}, 64'(busy),          64'(m_on));
      chk({ctx, ".qie"},  64'(qie_reset_out), 64'(live && m_pos < qw));
      chk({ctx, ".wte"},  64'(wte_out),       64'(live && m_pos == m_off && !m_err));
      chk({ctx, ".err"},  64'(cfg_err),       64'(m_err));
      chk({ctx, ".orb"},  64'(orbit_count),   64'(m_cnt));
   endtask

   task automatic cyc(input string ctx);
      @(posedge clk);
      if (reset_in) model_step();
      @(negedge clk);
      check_all(ctx);
   endtask

   initial begin
      int qn, wn, prev_rise, gap;
      logic prev_q;

      model_reset();
      repeat (3) @(negedge clk);
      check_all("rst");
      reset_in = 1'b1;

      // Periodic mode, period 10, offset 3.
      mode = 2'd0; cfg_period = 10; cfg_wte_offset = 3; enable = 1'b1;
      for (int i = 0; i < 50; i++) begin
         cyc("s1");
         if (i == 3) chk("s1.wte_c4", 64'(wte_out), 64'(1));
         if (i == 4) chk("s1.qie_c5", 64'(qie_reset_out), 64'(0));
      end
      chk("s1.orb50", 64'(orbit_count), 64'(5));
      enable = 1'b0;
      repeat (12) cyc("s1.stop");

      // Single-shot: one frame per start from idle.
      mode = 2'd2; cfg_period = 8; cfg_wte_offset = 7; enable = 1'b1;
      qn = 0; wn = 0;
      for (int i = 0; i < 9; i++) begin
         cyc("s2");
         qn += int'(qie_reset_out);
         wn += int'(wte_out);
         if (i == 8) chk("s2.busy_drop", 64'(busy), 64'(0));
      end
      chk("s2.qie_cnt", 64'(qn), 64'(4));
      chk("s2.wte_cnt", 64'(wn), 64'(1));
      repeat (20) cyc("s2.rerun");
      enable = 1'b0;
      repeat (10) cyc("s2.stop");

      // External trigger, period 20.
      mode = 2'd1; cfg_period = 20; cfg_wte_offset = 5; enable = 1'b1;
      repeat (3) cyc("s3.wait");
      aux_in = 1'b1;
      repeat (3) cyc("s3.lat");
      chk("s3.lat2", 64'(qie_reset_out), 64'(0));
      cyc("s3.lat");
      chk("s3.lat3", 64'(qie_reset_out), 64'(1));
      aux_in = 1'b0;
      repeat (30) cyc("s3.hold");
      chk("s3.hold_busy", 64'(busy), 64'(1));
      aux_in = 1'b1;
      repeat (4) cyc("s3.retrig");
      aux_in = 1'b0;
      repeat (8) cyc("s3.run");
      aux_in = 1'b1;
      repeat (4) cyc("s3.mid");
      chk("s3.orb", 64'(orbit_count), 64'(3));
      aux_in = 1'b0;
      enable = 1'b0;
      repeat (25) cyc("s3.stop");

      // Stop mid-frame at phase 5; re-enable during drain is ignored.
      mode = 2'd0; cfg_period = 10; cfg_wte_offset = 3; enable = 1'b1;
      repeat (6) cyc("s4.run");
      enable = 1'b0;
      repeat (2) cyc("s4.drain");
      enable = 1'b1;
      repeat (2) cyc("s4.drain");
      chk("s4.busy_last", 64'(busy), 64'(1));
      cyc("s4.end");
      chk("s4.busy_idle", 64'(busy), 64'(0));
      chk("s4.qie_idle", 64'(qie_reset_out), 64'(0));
      enable = 1'b0;
      repeat (12) cyc("s4.stop");

      // Aux edge and enable fall on the same edge: no restart.
      mode = 2'd1; cfg_period = 10; cfg_wte_offset = 2; enable = 1'b1;
      aux_in = 1'b1;
      repeat (4) cyc("s4b.start");
      aux_in = 1'b0;
      repeat (3) cyc("s4b.run");
      aux_in = 1'b1;
      repeat (3) cyc("s4b.run");
      enable = 1'b0;
      repeat (12) cyc("s4b.drain");
      aux_in = 1'b0;
      chk("s4b.busy", 64'(busy), 64'(0));
      chk("s4b.orb", 64'(orbit_count), 64'(1));

      // Offset outside the frame: error flag, no WTE, reset unaffected.
      mode = 2'd0; cfg_period = 10; cfg_wte_offset = 15; enable = 1'b1;
      wn = 0; qn = 0;
      for (int i = 0; i < 25; i++) begin
         cyc("s5");
         wn += int'(wte_out);
         qn += int'(qie_reset_out);
      end
      chk("s5.err", 64'(cfg_err), 64'(1));
      chk("s5.wte_cnt", 64'(wn), 64'(0));
      chk("s5.qie_cnt", 64'(qn), 64'(12));
      enable = 1'b0;
      repeat (12) cyc("s5.stop");
      chk("s5.err_hold", 64'(cfg_err), 64'(1));

      // Period 0 selects the default frame length.
      cfg_period = 0; cfg_wte_offset = 3; enable = 1'b1;
      prev_q = 1'b0; prev_rise = -1; gap = 0;
      for (int i = 0; i < 2 * DEFP; i++) begin
         cyc("s6");
         if (qie_reset_out && !prev_q) begin
            if (prev_rise >= 0) gap = i - prev_rise;
            prev_rise = i;
         end
         prev_q = qie_reset_out;
      end
      chk("s6.len", 64'(gap), 64'(DEFP));
      enable = 1'b0;
      repeat (3) cyc("s6.stop");

      // Period 1 is clamped to 2.
      cfg_period = 1; cfg_wte_offset = 1; enable = 1'b1;
      prev_q = 1'b0; prev_rise = -1; gap = 0;
      for (int i = 0; i < 10; i++) begin
         cyc("s7");
         if (qie_reset_out && !prev_q) begin
            if (prev_rise >= 0) gap = i - prev_rise;
            prev_rise = i;
         end
         prev_q = qie_reset_out;
      end
      chk("s7.len", 64'(gap), 64'(2));
      enable = 1'b0;
      repeat (4) cyc("s7.stop");

      // Randomized run: config churns freely, mode changes only while idle.
      for (int i = 0; i < 4000; i++) begin
         if (!m_on && $urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) cfg_period = PW'($urandom_range(1, 24));
         if ($urandom_range(0, 7) == 0) cfg_wte_offset = PW'($urandom_range(0, 28));
         if ($urandom_range(0, 24) == 0) enable = ~enable;
         if ($urandom_range(0, 5) == 0) aux_in = ~aux_in;
         cyc("rnd");
      end
      enable = 1'b0; aux_in = 1'b0;
      repeat (30) cyc("rnd.stop");

      // Asynchronous reset mid-frame, then a fresh periodic start.
      mode = 2'd0; cfg_period = 10; cfg_wte_offset = 3; enable = 1'b1;
      repeat (13) cyc("s8.run");
      @(posedge clk);
      model_step();
      #2;
      reset_in = 1'b0;
      model_reset();
      #1;
      chk("s8.rst_qie",  64'(qie_reset_out), 64'(0));
      chk("s8.rst_wte",  64'(wte_out),       64'(0));
      chk("s8.rst_busy", 64'(busy),          64'(0));
      chk("s8.rst_orb",  64'(orbit_count),   64'(0));
      chk("s8.rst_err",  64'(cfg_err),       64'(0));
      @(negedge clk);
      reset_in = 1'b1;
      for (int i = 0; i < 50; i++) begin
         cyc("s8.fresh");
         if (i == 3) chk("s8.wte_c4", 64'(wte_out), 64'(1));
      end
      chk("s8.orb50", 64'(orbit_count), 64'(5));
      enable = 1'b0;
      repeat (12) cyc("s8.stop");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
